// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: ALU opcodes, shift-op encodings
// and a small adder helper used for every arithmetic opcode.
package exec_pkg;

  // ARM data-processing opcodes
  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_EOR = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_RSB = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_ADC = 4'h5;
  localparam logic [3:0] ALU_SBC = 4'h6;
  localparam logic [3:0] ALU_RSC = 4'h7;
  localparam logic [3:0] ALU_TST = 4'h8;
  localparam logic [3:0] ALU_TEQ = 4'h9;
  localparam logic [3:0] ALU_CMP = 4'hA;
  localparam logic [3:0] ALU_CMN = 4'hB;
  localparam logic [3:0] ALU_ORR = 4'hC;
  localparam logic [3:0] ALU_MOV = 4'hD;
  localparam logic [3:0] ALU_BIC = 4'hE;
  localparam logic [3:0] ALU_MVN = 4'hF;

  // Shift ops: bits [2:1] pick the kind, bit 0 selects register-amount rules
  localparam logic [2:0] SHOP_LSL_IMM = 3'b000;
  localparam logic [2:0] SHOP_LSL_REG = 3'b001;
  localparam logic [2:0] SHOP_LSR_IMM = 3'b010;
  localparam logic [2:0] SHOP_LSR_REG = 3'b011;
  localparam logic [2:0] SHOP_ASR_IMM = 3'b100;
  localparam logic [2:0] SHOP_ASR_REG = 3'b101;
  localparam logic [2:0] SHOP_ROR_IMM = 3'b110;
  localparam logic [2:0] SHOP_ROR_REG = 3'b111;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_kind_e;

  // 33-bit add with carry-in; bit 32 is the carry-out (NOT borrow for x + ~y)
  function automatic logic [32:0] add33(input logic [31:0] x, input logic [31:0] y,
                                        input logic cin);
    return {1'b0, x} + {1'b0, y} + {32'h0000_0000, cin};
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Operand/control bundle between the controller and the execute stage.
interface exec_unit_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] r_data_a;
  logic [DATA_W-1:0] r_data_b;
  logic [DATA_W-1:0] r_data_c;
  logic              LA;
  logic              LB;
  logic              LC;
  logic              LF;
  logic              S_ctrl;
  logic              rm_imm_s_ctrl;
  logic [1:0]        rs_imm_s_ctrl;
  logic [2:0]        Shift_OP_ctrl;
  logic [3:0]        ALU_OP_ctrl;
  logic [4:0]        imm5;
  logic [11:0]       imm12;
  logic [DATA_W-1:0] F;
  logic [3:0]        NZCV;

  modport master (
    output r_data_a, r_data_b, r_data_c, LA, LB, LC, LF, S_ctrl,
           rm_imm_s_ctrl, rs_imm_s_ctrl, Shift_OP_ctrl, ALU_OP_ctrl, imm5, imm12,
    input  F, NZCV
  );

  modport slave (
    input  r_data_a, r_data_b, r_data_c, LA, LB, LC, LF, S_ctrl,
           rm_imm_s_ctrl, rs_imm_s_ctrl, Shift_OP_ctrl, ALU_OP_ctrl, imm5, imm12,
    output F, NZCV
  );
endinterface

// File: rtl/barrel_shift32.sv
// Combinational ARM barrel shifter with immediate- and register-amount rules.
// Immediate rules look only at amt[4:0]; a zero there encodes LSR/ASR #32 and RRX.
module barrel_shift32
  import exec_pkg::*;
(
  input  logic [31:0] data,
  input  logic [7:0]  amt,
  input  logic [2:0]  op,
  input  logic        cin,
  output logic [31:0] dout,
  output logic        cout
);

  shift_kind_e kind_s;
  logic [7:0]  n_s;
  logic        bypass_s;
  logic        rrx_s;
  logic [5:0]  asr_n_s;
  logic [4:0]  rot_s;
  logic [32:0] lsl_s;
  logic [32:0] lsr_s;
  logic [32:0] asr_s;
  logic [31:0] ror_s;

  assign kind_s = shift_kind_e'(op[2:1]);

  // Resolve the effective amount and the pass-through / RRX special cases
  always_comb begin
    n_s      = amt;
    bypass_s = 1'b0;
    rrx_s    = 1'b0;
    if (op[0] == 1'b0) begin
      n_s = {3'b000, amt[4:0]};
      if (amt[4:0] == 5'd0) begin
        case (kind_s)
          SH_LSL:         bypass_s = 1'b1;
          SH_LSR, SH_ASR: n_s      = 8'd32;
          SH_ROR:         rrx_s    = 1'b1;
          default:        bypass_s = 1'b1;
        endcase
      end else begin
        bypass_s = 1'b0;
      end
    end else begin
      bypass_s = (amt == 8'd0);
    end
  end

  // Extra bit beside the data word catches the last bit shifted out
  assign asr_n_s = (n_s >= 8'd32) ? 6'd32 : n_s[5:0];
  assign rot_s   = n_s[4:0];
  assign lsl_s   = {1'b0, data} << n_s;
  assign lsr_s   = {data, 1'b0} >> n_s;
  assign asr_s   = $signed({data, 1'b0}) >>> asr_n_s;
  assign ror_s   = (data >> rot_s) | (data << (6'd32 - {1'b0, rot_s}));

  // Select the shifted word and its carry-out
  always_comb begin
    dout = data;
    cout = cin;
    if (bypass_s) begin
      dout = data;
      cout = cin;
    end else if (rrx_s) begin
      dout = {cin, data[31:1]};
      cout = data[0];
    end else begin
      case (kind_s)
        SH_LSL:  begin dout = lsl_s[31:0];  cout = lsl_s[32]; end
        SH_LSR:  begin dout = lsr_s[32:1];  cout = lsr_s[0];  end
        SH_ASR:  begin dout = asr_s[32:1];  cout = asr_s[0];  end
        SH_ROR:  begin dout = ror_s;        cout = ror_s[31]; end
        default: begin dout = data;         cout = cin;       end
      endcase
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: operand registers, shifter operand muxes, ALU, result and
// flag registers. All state changes on the falling edge of clk.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  exec_unit_if.slave bus
);

  logic [DATA_W-1:0] a_r, b_r, c_r, f_r;
  logic [3:0]        nzcv_r;

  logic [31:0] sh_data_s;
  logic [7:0]  sh_amt_s;
  logic [31:0] bs_s;
  logic        sh_c_s;
  logic [31:0] x_s, y_s;
  logic        cin_s;
  logic        arith_s;
  logic [32:0] sum_s;
  logic [31:0] res_s;
  logic [3:0]  flags_s;

  // Shifter data and amount source selection
  always_comb begin
    if (bus.rm_imm_s_ctrl) begin
      sh_data_s = {24'h00_0000, bus.imm12[7:0]};
    end else begin
      sh_data_s = b_r;
    end
    if (bus.rs_imm_s_ctrl[1]) begin
      sh_amt_s = {3'b000, bus.imm12[11:8], 1'b0};
    end else if (bus.rs_imm_s_ctrl[0]) begin
      sh_amt_s = c_r[7:0];
    end else begin
      sh_amt_s = {3'b000, bus.imm5};
    end
  end

  barrel_shift32 u_shift (
    .data (sh_data_s),
    .amt  (sh_amt_s),
    .op   (bus.Shift_OP_ctrl),
    .cin  (nzcv_r[1]),
    .dout (bs_s),
    .cout (sh_c_s)
  );

  // Map every arithmetic opcode onto one adder: x + y + cin
  always_comb begin
    x_s     = a_r;
    y_s     = bs_s;
    cin_s   = 1'b0;
    arith_s = 1'b1;
    case (bus.ALU_OP_ctrl)
      ALU_SUB, ALU_CMP: begin x_s = a_r;  y_s = ~bs_s; cin_s = 1'b1;      end
      ALU_RSB:          begin x_s = bs_s; y_s = ~a_r;  cin_s = 1'b1;      end
      ALU_ADD, ALU_CMN: begin x_s = a_r;  y_s = bs_s;  cin_s = 1'b0;      end
      ALU_ADC:          begin x_s = a_r;  y_s = bs_s;  cin_s = nzcv_r[1]; end
      ALU_SBC:          begin x_s = a_r;  y_s = ~bs_s; cin_s = nzcv_r[1]; end
      ALU_RSC:          begin x_s = bs_s; y_s = ~a_r;  cin_s = nzcv_r[1]; end
      default:          arith_s = 1'b0;
    endcase
  end

  assign sum_s = add33(x_s, y_s, cin_s);

  // Result word and the flags it would produce
  always_comb begin
    case (bus.ALU_OP_ctrl)
      ALU_AND, ALU_TST: res_s = a_r & bs_s;
      ALU_EOR, ALU_TEQ: res_s = a_r ^ bs_s;
      ALU_ORR:          res_s = a_r | bs_s;
      ALU_MOV:          res_s = bs_s;
      ALU_BIC:          res_s = a_r & ~bs_s;
      ALU_MVN:          res_s = ~bs_s;
      default:          res_s = sum_s[31:0];
    endcase
    flags_s[3] = res_s[31];
    flags_s[2] = (res_s == 32'h0000_0000);
    if (arith_s) begin
      flags_s[1] = sum_s[32];
      flags_s[0] = (x_s[31] == y_s[31]) && (sum_s[31] != x_s[31]);
    end else begin
      flags_s[1] = sh_c_s;
      flags_s[0] = nzcv_r[0];
    end
  end

  // Operand, result and flag registers; reset wins over every load enable
  always_ff @(negedge clk) begin
    if (!rst) begin
      a_r    <= {DATA_W{1'b0}};
      b_r    <= {DATA_W{1'b0}};
      c_r    <= {DATA_W{1'b0}};
      f_r    <= {DATA_W{1'b0}};
      nzcv_r <= 4'b0000;
    end else begin
      if (bus.LA)     a_r    <= bus.r_data_a;
      if (bus.LB)     b_r    <= bus.r_data_b;
      if (bus.LC)     c_r    <= bus.r_data_c;
      if (bus.LF)     f_r    <= res_s;
      if (bus.S_ctrl) nzcv_r <= flags_s;
    end
  end

  assign bus.F    = f_r;
  assign bus.NZCV = nzcv_r;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed cases with literal expectations, then random
// cycles checked against a bit-serial reference model.
module tb_exec_unit;
  import exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exec_unit_if #(.DATA_W(32)) bus ();

  exec_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, la, lb, lc, lf, s, rm_imm;
    logic [1:0]  rs_imm;
    logic [2:0]  sop;
    logic [3:0]  aop;
    logic [4:0]  i5;
    logic [11:0] i12;
    logic [31:0] da, db, dc;
  } stim_t;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  logic [31:0] m_a = 32'h0, m_b = 32'h0, m_c = 32'h0, m_f = 32'h0;
  logic [3:0]  m_nzcv = 4'h0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.la = 1'b0; s.lb = 1'b0; s.lc = 1'b0; s.lf = 1'b0; s.s = 1'b0;
    s.rm_imm = 1'b0; s.rs_imm = 2'b00; s.sop = SHOP_LSL_IMM; s.aop = ALU_AND;
    s.i5 = 5'd0; s.i12 = 12'h000; s.da = 32'h0; s.db = 32'h0; s.dc = 32'h0;
    return s;
  endfunction

  // Shift one bit position at a time; carry is whatever fell off last.
  function automatic void model_shift(input logic [31:0] d, input logic [7:0] amt,
                                      input logic [2:0] op, input logic cf,
                                      output logic [31:0] o, output logic c);
    int n;
    int kind;
    logic [31:0] x;
    logic cc;
    x = d; cc = cf; kind = int'(op[2:1]); n = int'(amt);
    if (op[0] == 1'b0) begin
      n = int'(amt[4:0]);
      if (n == 0 && (kind == 1 || kind == 2)) n = 32;
      if (n == 0 && kind == 3) begin
        o = {cf, d[31:1]};
        c = d[0];
        return;
      end
    end
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       begin cc = x[31]; x = {x[30:0], 1'b0}; end
        1:       begin cc = x[0];  x = {1'b0, x[31:1]}; end
        2:       begin cc = x[0];  x = {x[31], x[31:1]}; end
        default: begin cc = x[0];  x = {x[0], x[31:1]}; end
      endcase
    end
    o = x; c = cc;
  endfunction

  // Integer arithmetic: r = x (+|-) y + adj; C from unsigned range, V from signed range.
  function automatic void model_arith(input logic [31:0] x, input logic [31:0] y,
                                      input bit is_sub, input longint adj,
                                      output logic [31:0] r, output logic c, output logic v);
    longint ux, uy, sx, sy, ur, sr;
    ux = longint'({32'h0, x}); uy = longint'({32'h0, y});
    sx = longint'($signed(x)); sy = longint'($signed(y));
    if (is_sub) begin
      ur = ux - uy + adj; sr = sx - sy + adj; c = (ur >= 64'sd0);
    end else begin
      ur = ux + uy + adj; sr = sx + sy + adj; c = (ur >= 64'sd4294967296);
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r = ur[31:0];
  endfunction

  function automatic void model_eval(input stim_t s, output logic [31:0] res,
                                     output logic [3:0] fl);
    logic [31:0] sd, bs;
    logic [7:0]  amt;
    logic        sc, c, v;
    longint      brw;
    sd  = s.rm_imm ? {24'h0, s.i12[7:0]} : m_b;
    amt = s.rs_imm[1] ? {3'd0, s.i12[11:8], 1'b0} : (s.rs_imm[0] ? m_c[7:0] : {3'd0, s.i5});
    model_shift(sd, amt, s.sop, m_nzcv[1], bs, sc);
    c = sc; v = m_nzcv[0];
    brw = m_nzcv[1] ? 64'sd0 : -64'sd1;
    case (s.aop)
      4'h0, 4'h8: res = m_a & bs;
      4'h1, 4'h9: res = m_a ^ bs;
      4'hC:       res = m_a | bs;
      4'hD:       res = bs;
      4'hE:       res = m_a & ~bs;
      4'hF:       res = ~bs;
      4'h2, 4'hA: model_arith(m_a, bs, 1'b1, 64'sd0, res, c, v);
      4'h3:       model_arith(bs, m_a, 1'b1, 64'sd0, res, c, v);
      4'h4, 4'hB: model_arith(m_a, bs, 1'b0, 64'sd0, res, c, v);
      4'h5:       model_arith(m_a, bs, 1'b0, m_nzcv[1] ? 64'sd1 : 64'sd0, res, c, v);
      4'h6:       model_arith(m_a, bs, 1'b1, brw, res, c, v);
      default:    model_arith(bs, m_a, 1'b1, brw, res, c, v);
    endcase
    fl = {res[31], res == 32'h0, c, v};
  endfunction

  // Drive one cycle, advance the model at the falling edge, check at the rising edge.
  task automatic apply(input stim_t s, input string tag);
    logic [31:0] res;
    logic [3:0]  fl;
    rst = s.rst;
    bus.LA = s.la; bus.LB = s.lb; bus.LC = s.lc; bus.LF = s.lf; bus.S_ctrl = s.s;
    bus.rm_imm_s_ctrl = s.rm_imm; bus.rs_imm_s_ctrl = s.rs_imm;
    bus.Shift_OP_ctrl = s.sop; bus.ALU_OP_ctrl = s.aop;
    bus.imm5 = s.i5; bus.imm12 = s.i12;
    bus.r_data_a = s.da; bus.r_data_b = s.db; bus.r_data_c = s.dc;
    @(negedge clk);
    if (!s.rst) begin
      m_a = 32'h0; m_b = 32'h0; m_c = 32'h0; m_f = 32'h0; m_nzcv = 4'h0;
    end else begin
      model_eval(s, res, fl);
      if (s.lf) m_f = res;
      if (s.s)  m_nzcv = fl;
      if (s.la) m_a = s.da;
      if (s.lb) m_b = s.db;
      if (s.lc) m_c = s.dc;
    end
    @(posedge clk);
    #1;
    vectors++;
    assert (bus.F === m_f) else begin
      miscompares++;
      $error("FAIL %s F observed=%h expected=%h", tag, bus.F, m_f);
    end
    vectors++;
    assert (bus.NZCV === m_nzcv) else begin
      miscompares++;
      $error("FAIL %s NZCV observed=%b expected=%b", tag, bus.NZCV, m_nzcv);
    end
  endtask

  task automatic expect_const(input string tag, input logic [31:0] f, input logic [3:0] nz);
    vectors++;
    assert (bus.F === f) else begin
      miscompares++;
      $error("FAIL %s_lit F observed=%h expected=%h", tag, bus.F, f);
    end
    vectors++;
    assert (bus.NZCV === nz) else begin
      miscompares++;
      $error("FAIL %s_lit NZCV observed=%b expected=%b", tag, bus.NZCV, nz);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    stim_t s;

    // reset with loads asserted: everything clears
    s = idle(); s.rst = 1'b0; s.la = 1'b1; s.lb = 1'b1; s.lf = 1'b1; s.s = 1'b1;
    s.da = 32'h1234_5678; s.db = 32'h9ABC_DEF0; s.aop = ALU_ADD;
    apply(s, "reset");                expect_const("reset", 32'h0, 4'b0000);

    // ADD overflow to zero
    s = idle(); s.la = 1'b1; s.lb = 1'b1; s.da = 32'hFFFF_FFFF; s.db = 32'h1;
    apply(s, "load_ab");              expect_const("load_ab", 32'h0, 4'b0000);
    s = idle(); s.aop = ALU_ADD; s.lf = 1'b1; s.s = 1'b1;
    apply(s, "add_wrap");             expect_const("add_wrap", 32'h0, 4'b0110);

    // SUB signed overflow
    s = idle(); s.la = 1'b1; s.da = 32'h8000_0000;
    apply(s, "load_a");               expect_const("load_a", 32'h0, 4'b0110);
    s = idle(); s.aop = ALU_SUB; s.lf = 1'b1; s.s = 1'b1;
    apply(s, "sub_ovf");              expect_const("sub_ovf", 32'h7FFF_FFFF, 4'b0011);

    // immediate rotate, register rule
    s = idle(); s.rst = 1'b0;
    apply(s, "reset2");               expect_const("reset2", 32'h0, 4'b0000);
    s = idle(); s.rm_imm = 1'b1; s.i12 = 12'h4FF; s.rs_imm = 2'b10;
    s.sop = SHOP_ROR_REG; s.aop = ALU_MOV; s.lf = 1'b1; s.s = 1'b1;
    apply(s, "ror_imm12");            expect_const("ror_imm12", 32'hFF00_0000, 4'b1010);

    // RRX with carry set
    s = idle(); s.lb = 1'b1; s.db = 32'h3;
    apply(s, "load_b3");              expect_const("load_b3", 32'hFF00_0000, 4'b1010);
    s = idle(); s.sop = SHOP_ROR_IMM; s.aop = ALU_MOV; s.lf = 1'b1; s.s = 1'b1;
    apply(s, "rrx");                  expect_const("rrx", 32'h8000_0001, 4'b1010);

    // LSR by register amount above 32
    s = idle(); s.lb = 1'b1; s.lc = 1'b1; s.db = 32'h8000_0000; s.dc = 32'd40;
    apply(s, "load_bc");              expect_const("load_bc", 32'h8000_0001, 4'b1010);
    s = idle(); s.rs_imm = 2'b01; s.sop = SHOP_LSR_REG; s.aop = ALU_MOV;
    s.lf = 1'b1; s.s = 1'b1;
    apply(s, "lsr40");                expect_const("lsr40", 32'h0, 4'b0100);

    // operand load and result load together: result uses the old operands
    s = idle(); s.la = 1'b1; s.lb = 1'b1; s.da = 32'h1; s.db = 32'h1;
    s.aop = ALU_ADD; s.lf = 1'b1;
    apply(s, "old_ops");              expect_const("old_ops", 32'h8000_0000, 4'b0100);
    s = idle(); s.aop = ALU_ADD; s.lf = 1'b1; s.s = 1'b1;
    apply(s, "new_ops");              expect_const("new_ops", 32'h2, 4'b0000);

    // reset in the middle of an operation
    s = idle(); s.rst = 1'b0; s.aop = ALU_ADD; s.lf = 1'b1; s.s = 1'b1;
    apply(s, "rst_mid");              expect_const("rst_mid", 32'h0, 4'b0000);

    // random cycles against the model
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst    = ($urandom_range(0, 59) != 0);
      s.la     = $urandom_range(0, 1) != 0;
      s.lb     = $urandom_range(0, 1) != 0;
      s.lc     = $urandom_range(0, 1) != 0;
      s.lf     = $urandom_range(0, 3) != 0;
      s.s      = $urandom_range(0, 2) != 0;
      s.rm_imm = $urandom_range(0, 3) == 0;
      s.sop    = 3'($urandom_range(0, 7));
      s.rs_imm = s.sop[0] ? 2'($urandom_range(0, 3)) : 2'b00;
      s.aop    = 4'($urandom_range(0, 15));
      s.i5     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      s.i12    = 12'($urandom);
      s.da     = rnd_word();
      s.db     = rnd_word();
      case ($urandom_range(0, 3))
        0:       s.dc = 32'($urandom_range(0, 70));
        1:       s.dc = {24'($urandom), 8'd32};
        2:       s.dc = {24'($urandom), 3'($urandom_range(1, 7)), 5'd0};
        default: s.dc = $urandom;
      endcase
      apply(s, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
